// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - program memory fetch port between pc_fetch and program memory
interface pc_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_valid
    );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter, byte fetch sequencer and return-address stack
module pc_fetch #(
    parameter int          STACK_DEPTH  = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_next,
    input  logic              halt,
    pc_fetch_if.master        mem,
    output logic [7:0]        data_out,
    output logic              byte_valid,
    input  logic              jmp_pcoe,
    input  logic [15:0]       jmp_pcout,
    input  logic              call,
    input  logic              ret,
    output logic [15:0]       pc,
    output logic              busy,
    output logic              stk_ovf,
    output logic              stk_unf
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(STACK_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] sp_q;
    logic [15:0]   stack_mem [STACK_DEPTH];

    logic          is_idle;
    logic          stack_full;
    logic          stack_empty;
    logic          do_call;
    logic          do_jump;
    logic          do_ret;
    logic          push_en;
    logic          pop_en;
    logic          fetch_done;
    logic [AW-1:0] top_idx;

    // Redirects are only honoured in IDLE; a pending fetch owns the PC until it lands.
    assign is_idle     = (state_q == S_IDLE);
    assign stack_full  = (sp_q >= DEPTH_C);
    assign stack_empty = (sp_q == '0);
    assign do_call     = is_idle && jmp_pcoe && call;
    assign do_jump     = is_idle && jmp_pcoe;
    assign do_ret      = is_idle && !jmp_pcoe && ret;
    assign push_en     = do_call && !stack_full;
    assign pop_en      = do_ret && !stack_empty;
    assign fetch_done  = (state_q == S_WAIT) && mem.mem_valid;
    // Low bits of sp-1; wraps correctly when sp equals STACK_DEPTH.
    assign top_idx     = sp_q[AW-1:0] - AW'(1);

    // State register; reset aborts any outstanding fetch immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE launches a fetch unless halted, WAIT leaves on mem_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fetch_next && !halt) state_d = S_WAIT;
            S_WAIT: if (mem.mem_valid)       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the fetch address always follows pc.
    always_comb begin
        mem.mem_req  = (state_q == S_WAIT);
        busy         = (state_q == S_WAIT);
        mem.mem_addr = pc;
    end

    // PC, fetched byte, stack pointer and sticky stack error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            data_out   <= 8'h00;
            byte_valid <= 1'b0;
            sp_q       <= '0;
            stk_ovf    <= 1'b0;
            stk_unf    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (fetch_done) begin
                data_out   <= mem.mem_rdata;
                byte_valid <= 1'b1;
                pc         <= pc + 16'h0001;
            end else if (do_call) begin
                if (push_en) sp_q <= sp_q + PW'(1);
                else         stk_ovf <= 1'b1;
                pc <= jmp_pcout;
            end else if (do_jump) begin
                pc <= jmp_pcout;
            end else if (do_ret) begin
                if (pop_en) begin
                    pc   <= stack_mem[top_idx];
                    sp_q <= sp_q - PW'(1);
                end else begin
                    stk_unf <= 1'b1;
                end
            end
        end
    end

    // Return-address storage; contents survive reset, only sp is cleared.
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            stack_mem[sp_q[AW-1:0]] <= pc;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_next = 1'b0;
    logic        halt = 1'b0;
    logic        jmp_pcoe = 1'b0;
    logic [15:0] jmp_pcout = 16'h0000;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [7:0]  data_out;
    logic        byte_valid;
    logic [15:0] pc;
    logic        busy;
    logic        stk_ovf;
    logic        stk_unf;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    pc_fetch_if mif();

    pc_fetch #(.STACK_DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_next (fetch_next),
        .halt       (halt),
        .mem        (mif),
        .data_out   (data_out),
        .byte_valid (byte_valid),
        .jmp_pcoe   (jmp_pcoe),
        .jmp_pcout  (jmp_pcout),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .busy       (busy),
        .stk_ovf    (stk_ovf),
        .stk_unf    (stk_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        fetch_next = 1'b0; halt = 1'b0; jmp_pcoe = 1'b0; call = 1'b0; ret = 1'b0;
        mif.mem_valid = 1'b0; mif.mem_rdata = 8'h00;
        repeat (2) step();
        rst = 1'b1;
        m_pc = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_data = 8'h00;
    endtask

    // One complete fetch from IDLE with lat wait cycles before mem_valid.
    task automatic fetch(input int lat, input logic [7:0] d, input logic halt_wait);
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        halt = halt_wait;
        repeat (lat) step();
        mif.mem_valid = 1'b1;
        mif.mem_rdata = d;
        step();
        mif.mem_valid = 1'b0;
        halt = 1'b0;
        m_pc = m_pc + 16'h0001;
        m_data = d;
    endtask

    // One-cycle redirect request in IDLE, with the model's view of its effect.
    task automatic redirect(input logic j, input logic c, input logic r, input logic [15:0] t);
        jmp_pcoe = j; call = c; ret = r; jmp_pcout = t;
        step();
        jmp_pcoe = 1'b0; call = 1'b0; ret = 1'b0;
        if (j && c) begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc);
            else m_ovf = 1'b1;
            m_pc = t;
        end else if (j) begin
            m_pc = t;
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1'b1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got %h exp 0000", pc); end
        vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b exp 0", mif.mem_req); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if ({stk_ovf, stk_unf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b%b exp 00", stk_ovf, stk_unf); end
        vectors++; if ({data_out, byte_valid} !== 9'h000) begin miscompares++; $display("FAIL reset_data got %h/%b exp 00/0", data_out, byte_valid); end
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        vectors++; if (mif.mem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b exp 1", mif.mem_req); end
        vectors++; if (mif.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL first_addr got %h exp 0000", mif.mem_addr); end
        mif.mem_valid = 1'b1; mif.mem_rdata = 8'h3C;
        step();
        mif.mem_valid = 1'b0;
        m_pc = 16'h0001; m_data = 8'h3C;
        vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL first_data got %h exp 3c", data_out); end
        vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL first_pc got %h exp 0001", pc); end
    endtask

    task automatic test_wait_states();
        int bv = 0;
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mif.mem_addr !== 16'h0001 || busy !== 1'b1) begin miscompares++; $display("FAIL wait_hold[%0d] got %h/%b exp 0001/1", i, mif.mem_addr, busy); end
            mif.mem_rdata = 8'($urandom);
            step();
        end
        mif.mem_valid = 1'b1; mif.mem_rdata = 8'hA5;
        step();
        mif.mem_valid = 1'b0;
        m_pc = 16'h0002; m_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            if (byte_valid === 1'b1) bv++;
            if (i < 2) step();
        end
        vectors++; if (bv !== 1) begin miscompares++; $display("FAIL wait_pulse_count got %0d exp 1", bv); end
        vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("FAIL wait_data got %h exp a5", data_out); end
        vectors++; if (pc !== 16'h0002) begin miscompares++; $display("FAIL wait_pc got %h exp 0002", pc); end
    endtask

    task automatic test_jump_busy();
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        jmp_pcoe = 1'b1; jmp_pcout = 16'h1234; ret = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (pc !== 16'h0002) begin miscompares++; $display("FAIL jump_busy_pc[%0d] got %h exp 0002", i, pc); end
            step();
        end
        mif.mem_valid = 1'b1; mif.mem_rdata = 8'h11;
        step();
        mif.mem_valid = 1'b0;
        vectors++; if (pc !== 16'h0003 || busy !== 1'b0) begin miscompares++; $display("FAIL jump_after_fetch got %h/%b exp 0003/0", pc, busy); end
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0; jmp_pcoe = 1'b0; ret = 1'b0;
        vectors++; if (pc !== 16'h1234 || mif.mem_addr !== 16'h1234) begin miscompares++; $display("FAIL jump_fetch_addr got %h/%h exp 1234", pc, mif.mem_addr); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL jump_fetch_busy got %b exp 1", busy); end
        mif.mem_valid = 1'b1; mif.mem_rdata = 8'h22;
        step();
        mif.mem_valid = 1'b0;
        m_pc = 16'h1235; m_data = 8'h22;
        vectors++; if (pc !== 16'h1235 || data_out !== 8'h22) begin miscompares++; $display("FAIL jump_fetch_done got %h/%h exp 1235/22", pc, data_out); end
    endtask

    task automatic test_call_ret();
        redirect(1'b1, 1'b0, 1'b0, 16'h0010);
        vectors++; if (pc !== 16'h0010) begin miscompares++; $display("FAIL cr_jump got %h exp 0010", pc); end
        redirect(1'b1, 1'b1, 1'b0, 16'h0200);
        vectors++; if (pc !== 16'h0200) begin miscompares++; $display("FAIL cr_call got %h exp 0200", pc); end
        redirect(1'b0, 1'b0, 1'b1, 16'hBEEF);
        vectors++; if (pc !== 16'h0010 || stk_unf !== 1'b0) begin miscompares++; $display("FAIL cr_ret got %h/%b exp 0010/0", pc, stk_unf); end
        redirect(1'b0, 1'b0, 1'b1, 16'hBEEF);
        vectors++; if (pc !== 16'h0010 || stk_unf !== 1'b1) begin miscompares++; $display("FAIL cr_underflow got %h/%b exp 0010/1", pc, stk_unf); end
    endtask

    task automatic test_overflow();
        logic [15:0] t;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            t = 16'(i << 12);
            redirect(1'b1, 1'b1, 1'b0, t);
            vectors++; if (pc !== t || stk_ovf !== (i == 5)) begin miscompares++; $display("FAIL ovf_call[%0d] got %h/%b exp %h/%b", i, pc, stk_ovf, t, (i == 5)); end
        end
        for (int k = 0; k < 4; k++) begin
            t = 16'((3 - k) << 12);
            redirect(1'b0, 1'b0, 1'b1, 16'h0000);
            vectors++; if (pc !== t) begin miscompares++; $display("FAIL ovf_ret[%0d] got %h exp %h", k, pc, t); end
        end
        vectors++; if (stk_ovf !== 1'b1 || stk_unf !== 1'b0) begin miscompares++; $display("FAIL ovf_sticky got %b%b exp 10", stk_ovf, stk_unf); end
    endtask

    task automatic test_wrap_reset();
        redirect(1'b1, 1'b0, 1'b0, 16'hFFFF);
        fetch(1, 8'h5A, 1'b1);
        vectors++; if (pc !== 16'h0000 || data_out !== 8'h5A) begin miscompares++; $display("FAIL wrap got %h/%h exp 0000/5a", pc, data_out); end
        redirect(1'b1, 1'b0, 1'b0, 16'h4321);
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        vectors++; if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_abort_req got %b/%b exp 0/0", mif.mem_req, busy); end
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rst_abort_pc got %h exp 0000", pc); end
        mif.mem_valid = 1'b1; mif.mem_rdata = 8'hEE;
        step();
        rst = 1'b1;
        step();
        mif.mem_valid = 1'b0;
        vectors++; if (pc !== 16'h0000 || byte_valid !== 1'b0 || data_out !== 8'h00) begin miscompares++; $display("FAIL rst_late_valid got %h/%b/%h exp 0000/0/00", pc, byte_valid, data_out); end
    endtask

    task automatic test_random();
        int op;
        logic [15:0] t;
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 6);
            t = 16'($urandom);
            case (op)
                0, 1: begin
                    fetch($urandom_range(0, 3), 8'($urandom), 1'($urandom));
                    vectors++; if (byte_valid !== 1'b1 || data_out !== m_data) begin miscompares++; $display("FAIL rnd_fetch[%0d] got %b/%h exp 1/%h", n, byte_valid, data_out, m_data); end
                end
                2: redirect(1'b1, 1'b0, 1'b0, t);
                3: redirect(1'b1, 1'b1, 1'b0, t);
                4: redirect(1'b0, 1'b0, 1'b1, t);
                5: redirect(1'b1, 1'b0, 1'b1, t);
                default: begin
                    redirect(1'b0, 1'b1, 1'b0, t);
                    halt = 1'b1; fetch_next = 1'b1; mif.mem_valid = 1'b1; mif.mem_rdata = 8'($urandom);
                    step();
                    halt = 1'b0; fetch_next = 1'b0; mif.mem_valid = 1'b0;
                    vectors++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_halt[%0d] got %b/%b exp 0/0", n, busy, byte_valid); end
                end
            endcase
            vectors++; if (pc !== m_pc || mif.mem_addr !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d] op %0d got %h/%h exp %h", n, op, pc, mif.mem_addr, m_pc); end
            vectors++; if (stk_ovf !== m_ovf || stk_unf !== m_unf) begin miscompares++; $display("FAIL rnd_flags[%0d] got %b%b exp %b%b", n, stk_ovf, stk_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        mif.mem_valid = 1'b0;
        mif.mem_rdata = 8'h00;
        test_reset();
        test_wait_states();
        test_jump_busy();
        test_call_ret();
        test_overflow();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
